// File: rtl/rv_pkg.sv
// Shared miniRV register-file definitions.
// Holds the default geometry of the integer register file, the architectural
// indices with special meaning (x0 hardwired zero, x2 stack pointer) and the
// index type used by anything that names a register.
package rv_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned ADDR_W   = 5;

    localparam int unsigned REG_ZERO = 0;
    localparam int unsigned REG_SP   = 2;

    typedef logic [ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/decoder_5to32.sv
// Enabled binary-to-one-hot decoder for register row selection.
// Ports:
//   en_i     - decode enable; all outputs low when clear
//   addr_i   - binary row index
//   onehot_o - one-hot row strobe; indices at or above NumRegs never assert
module decoder_5to32 #(
    parameter int unsigned AddrW   = 5,
    parameter int unsigned NumRegs = 32
) (
    input  logic               en_i,
    input  logic [AddrW-1:0]   addr_i,
    output logic [NumRegs-1:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        for (int k = 0; k < NumRegs; k++) begin
            onehot_o[k] = en_i && (addr_i == AddrW'(k));
        end
    end

endmodule

// File: rtl/regfile_write_bank.sv
// Storage and write side of the miniRV integer register file.
// A single write port byte-merges wdata into the addressed register; every
// register is exported flat for the read-port multiplexers. x0 has no storage
// and reads as zero; x2 resets to SP_RESET.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   we          - write request
//   waddr       - destination register index
//   wdata       - write data
//   wstrb       - byte-lane enables, bit i covers wdata[8i+7:8i]
//   regs_flat   - reg k at [k*XLEN +: XLEN]
//   wr_onehot   - combinational decoded row strobe (bit 0 always low)
//   last_waddr  - index of the most recent committed write
//   last_valid  - set once any write has committed since reset
//   wr_cnt      - committed-write counter, wraps
module regfile_write_bank #(
    parameter int unsigned XLEN     = rv_pkg::XLEN,
    parameter int unsigned NUM_REGS = rv_pkg::NUM_REGS,
    parameter int unsigned ADDR_W   = rv_pkg::ADDR_W,
    parameter logic [XLEN-1:0] SP_RESET = '0,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [XLEN-1:0]          wdata,
    input  logic [XLEN/8-1:0]        wstrb,
    output logic [NUM_REGS*XLEN-1:0] regs_flat,
    output logic [NUM_REGS-1:0]      wr_onehot,
    output logic [ADDR_W-1:0]        last_waddr,
    output logic                     last_valid,
    output logic [CNT_W-1:0]         wr_cnt
);

    import rv_pkg::*;

    localparam int unsigned NumBytes = XLEN / 8;
    // One extra bit so NUM_REGS = 2**ADDR_W is representable in the compare.
    localparam logic [ADDR_W:0] NumRegsW = (ADDR_W + 1)'(NUM_REGS);

    logic [NUM_REGS-1:0] dec_onehot;
    logic                commit;

    logic [ADDR_W-1:0] last_waddr_q, last_waddr_d;
    logic              last_valid_q, last_valid_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;

    decoder_5to32 #(
        .AddrW   (ADDR_W),
        .NumRegs (NUM_REGS)
    ) u_dec (
        .en_i     (we),
        .addr_i   (waddr),
        .onehot_o (dec_onehot)
    );

    // x0 never gets a strobe, whatever the decoder says.
    assign wr_onehot = dec_onehot & ~NUM_REGS'(1);

    assign commit = we && (waddr != '0) && ({1'b0, waddr} < NumRegsW) && (wstrb != '0);

    assign regs_flat[XLEN-1:0] = '0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_row
        localparam logic [XLEN-1:0] RstVal = (r == REG_SP) ? SP_RESET : '0;

        logic [XLEN-1:0] row_q, row_d;

        always_comb begin
            row_d = row_q;
            if (commit && wr_onehot[r]) begin
                for (int b = 0; b < NumBytes; b++) begin
                    if (wstrb[b]) begin
                        row_d[8*b +: 8] = wdata[8*b +: 8];
                    end
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                row_q <= RstVal;
            end else begin
                row_q <= row_d;
            end
        end

        assign regs_flat[r*XLEN +: XLEN] = row_q;
    end

    always_comb begin
        last_waddr_d = last_waddr_q;
        last_valid_d = last_valid_q;
        wr_cnt_d     = wr_cnt_q;
        if (commit) begin
            last_waddr_d = waddr;
            last_valid_d = 1'b1;
            wr_cnt_d     = wr_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_waddr_q <= '0;
            last_valid_q <= 1'b0;
            wr_cnt_q     <= '0;
        end else begin
            last_waddr_q <= last_waddr_d;
            last_valid_q <= last_valid_d;
            wr_cnt_q     <= wr_cnt_d;
        end
    end

    assign last_waddr = last_waddr_q;
    assign last_valid = last_valid_q;
    assign wr_cnt     = wr_cnt_q;

endmodule

// File: tb/tb_regfile_write_bank.sv
// Directed bench for regfile_write_bank: a vector table for single-cycle
// writes plus hand-written reset-during-write and counter-wrap sequences.
module tb_regfile_write_bank;

    import rv_pkg::*;

    localparam logic [31:0] SpReset = 32'h0000_F000;

    logic          clk;
    logic          rst_n;
    logic          we;
    reg_idx_t      waddr;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic [1023:0] regs_flat;
    logic [31:0]   wr_onehot;
    reg_idx_t      last_waddr;
    logic          last_valid;
    logic [15:0]   wr_cnt;

    int n_vec;
    int n_err;

    regfile_write_bank #(
        .XLEN     (32),
        .NUM_REGS (32),
        .ADDR_W   (5),
        .SP_RESET (SpReset),
        .CNT_W    (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .wstrb      (wstrb),
        .regs_flat  (regs_flat),
        .wr_onehot  (wr_onehot),
        .last_waddr (last_waddr),
        .last_valid (last_valid),
        .wr_cnt     (wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n) begin
            assert (!$isunknown(we)) else $error("we is X/Z while out of reset");
        end
    end

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_onehot;
        logic [31:0] exp_val;   // reg[waddr] after the edge
        logic [15:0] exp_cnt;
        logic [4:0]  exp_last;
        logic        exp_valid;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [31:0] reg_at(int k);
        return regs_flat[k*32 +: 32];
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset_state(string tag);
        for (int k = 0; k < 32; k++) begin
            chk($sformatf("%s reg%0d", tag, k), reg_at(k), (k == 2) ? SpReset : 32'h0);
        end
        chk({tag, " last_valid"}, 32'(last_valid), 32'h0);
        chk({tag, " last_waddr"}, 32'(last_waddr), 32'h0);
        chk({tag, " wr_cnt"}, 32'(wr_cnt), 32'h0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        we    = 1'b0;
        waddr = '0;
        wdata = '0;
        wstrb = '0;

        //            we waddr  wdata         wstrb    onehot        value         cnt last v
        vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 4'hF,    32'h0000_0020, 32'hDEADBEEF, 16'd1, 5'd5,  1'b1};
        vecs[1] = '{1'b1, 5'd5,  32'h11223344, 4'b0101, 32'h0000_0020, 32'hDE22BE44, 16'd2, 5'd5,  1'b1};
        vecs[2] = '{1'b1, 5'd0,  32'hFFFFFFFF, 4'hF,    32'h0000_0000, 32'h00000000, 16'd2, 5'd5,  1'b1};
        vecs[3] = '{1'b1, 5'd2,  32'hCAFEF00D, 4'b1000, 32'h0000_0004, 32'hCA00F000, 16'd3, 5'd2,  1'b1};
        vecs[4] = '{1'b0, 5'd7,  32'h12345678, 4'hF,    32'h0000_0000, 32'h00000000, 16'd3, 5'd2,  1'b1};
        vecs[5] = '{1'b1, 5'd7,  32'h12345678, 4'h0,    32'h0000_0080, 32'h00000000, 16'd3, 5'd2,  1'b1};
        vecs[6] = '{1'b1, 5'd31, 32'hA5A5A5A5, 4'b0011, 32'h8000_0000, 32'h0000A5A5, 16'd4, 5'd31, 1'b1};
        vecs[7] = '{1'b1, 5'd1,  32'h00000001, 4'b0001, 32'h0000_0002, 32'h00000001, 16'd5, 5'd1,  1'b1};

        // Reset, then release.
        repeat (2) @(posedge clk);
        #1 chk_reset_state("in-reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 chk_reset_state("post-reset");

        foreach (vecs[i]) begin
            @(negedge clk);
            we    = vecs[i].we;
            waddr = vecs[i].waddr;
            wdata = vecs[i].wdata;
            wstrb = vecs[i].wstrb;
            #1 chk($sformatf("v%0d wr_onehot", i), wr_onehot, vecs[i].exp_onehot);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d reg%0d", i, vecs[i].waddr), reg_at(int'(vecs[i].waddr)),
                vecs[i].exp_val);
            chk($sformatf("v%0d wr_cnt", i), 32'(wr_cnt), 32'(vecs[i].exp_cnt));
            chk($sformatf("v%0d last_waddr", i), 32'(last_waddr), 32'(vecs[i].exp_last));
            chk($sformatf("v%0d last_valid", i), 32'(last_valid), 32'(vecs[i].exp_valid));
        end
        chk("reg5 held", reg_at(5), 32'hDE22BE44);
        chk("reg0 zero", reg_at(0), 32'h0);

        // Reset dropped mid-cycle while a write is pending: reset wins at once.
        @(negedge clk);
        we    = 1'b1;
        waddr = 5'd9;
        wdata = 32'hFFFFFFFF;
        wstrb = 4'hF;
        #2 rst_n = 1'b0;
        #1 chk_reset_state("mid-cycle-reset");
        @(posedge clk);
        #1 chk("reg9 no commit under reset", reg_at(9), 32'h0);
        chk("wr_cnt no commit under reset", 32'(wr_cnt), 32'h0);
        @(negedge clk);
        we    = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1 chk_reset_state("after-reset-release");

        // Counter wrap: 65535 commits reach all-ones, one more wraps to zero.
        @(negedge clk);
        we    = 1'b1;
        waddr = 5'd3;
        wstrb = 4'h1;
        for (int i = 0; i < 65535; i++) begin
            wdata = 32'(i);
            @(posedge clk);
            #1;
        end
        chk("wr_cnt at all-ones", 32'(wr_cnt), 32'h0000_FFFF);
        chk("reg3 low byte", reg_at(3), 32'h0000_00FE);
        @(negedge clk);
        wdata = 32'h0000_0077;
        @(posedge clk);
        #1 chk("wr_cnt wraps", 32'(wr_cnt), 32'h0);
        chk("reg3 after wrap commit", reg_at(3), 32'h0000_0077);
        chk("last_valid after wrap", 32'(last_valid), 32'h1);

        // wstrb = 0 with we = 1: nothing moves.
        @(negedge clk);
        waddr = 5'd4;
        wdata = 32'hFFFF_FFFF;
        wstrb = 4'h0;
        @(posedge clk);
        #1 chk("wstrb0 reg4", reg_at(4), 32'h0);
        chk("wstrb0 wr_cnt", 32'(wr_cnt), 32'h0);
        chk("wstrb0 last_waddr", 32'(last_waddr), 32'h3);
        @(negedge clk);
        we = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
